data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port 32-word data memory between two requesters: the CPU load/store unit and the debug/loader port (test harness, board display).
- Grants at most one access per cycle and drives the memory's MemRead/MemWrite/ram_addr/write_data directly.
- Registers read data and returns it one cycle after grant.
- CPU normally wins conflicts; a starvation counter guarantees debug progress.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, requester/memory address width (word address)
- MEM_WORDS, 32, implemented memory depth; addresses >= MEM_WORDS are out of range
- STARVE_LIMIT, 4, consecutive lost debug cycles before debug is forced to win

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  access performed this cycle
- cpu_rvalid  out  1  cpu_rdata valid (cycle after granted read)
- cpu_rdata  out  DATA_W  registered read data
- cpu_err  out  1  pulse: granted access was out of range
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err: same as cpu_* for the debug port
- MemRead  out  1  to memory
- MemWrite  out  1  to memory
- ram_addr  out  ADDR_W  to memory
- write_data  out  DATA_W  to memory
- read_data  in  DATA_W  from memory (combinational read)

Behaviour:
- Clock is clk. Reset is synchronous, active-high.
- Reset value of every registered output (rvalid, rdata, err on both ports): 0. Starvation counter: 0.
- While reset=1, cpu_gnt, dbg_gnt, MemRead and MemWrite are forced to 0.
- Arbitration is combinational within the cycle:
  - Only one req high: that requester is granted.
  - Both high: CPU is granted unless starve_cnt >= STARVE_LIMIT, in which case debug is granted.
  - Neither high: no grant; MemRead=MemWrite=0; ram_addr/write_data = 0.
- Granted port drives the memory:
  - ram_addr = addr.
  - write_data = wdata.
  - MemWrite = we & in_range.
  - MemRead = ~we.
- Requester handshake:
  - Requester holds req/we/addr/wdata stable until gnt.
  - Request is consumed at the posedge where gnt=1.
  - Back-to-back grants to the same port are allowed every cycle.
- Read latency is 1 cycle. On a granted read, rdata <= read_data (0 if out of range) and rvalid <= 1 for exactly the following cycle. rdata holds its value otherwise.
- Write latency: memory updated at the grant posedge. A read granted the next cycle returns the new value.
- Out of range (addr >= MEM_WORDS):
  - Write is suppressed.
  - Read returns 0 with rvalid=1.
  - err pulses for 1 cycle, aligned with rvalid timing, for reads and writes alike.
- Starvation counter, updated at posedge:
  - Cleared when dbg_gnt or ~dbg_req.
  - Otherwise incremented when dbg_req & ~dbg_gnt, saturating at STARVE_LIMIT.
- Worst-case debug wait is STARVE_LIMIT+1 cycles under continuous CPU load.
- Reset mid-operation: a pending rvalid/err is cleared next cycle and no access is granted while reset=1. Requesters must reissue.
- Simultaneous reads of the same address by both ports resolve as two serial accesses.

Decomposition:
- Package mem_arb_pkg: requester-id enum {REQ_NONE, REQ_CPU, REQ_DBG} and the default STARVE_LIMIT constant.
- Sub-module mem_arb_port_resp, instantiated once per port: registers rvalid/rdata/err from (granted, we, in_range, read_data).
- Arbitration and the starvation counter stay in the top level.

Test Plan:
- Single CPU write then read: cpu write addr 5 data 0xDEADBEEF, next cycle read addr 5 -> cpu_gnt both cycles; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF one cycle after the read grant; dbg outputs stay 0.
- Conflict: both req reads in the same cycle (cpu addr 3, dbg addr 7, memory preloaded mem[i]=i) -> cycle 0 cpu_gnt; cycle 1 dbg_gnt; cpu_rdata=3, then dbg_rdata=7 on successive cycles.
- Starvation: cpu_req held high continuously, dbg_req high from cycle 0, STARVE_LIMIT=4 -> dbg_gnt at cycle 4; cpu_gnt=0 that cycle; counter returns to 0.
- Out of range: dbg write addr 40 data 0x1234, then read addr 40 -> MemWrite=0 on the write cycle; dbg_err pulses after each grant; read returns dbg_rdata=0 with dbg_rvalid=1.
- Reset mid-read: granted cpu read, assert reset the next cycle -> cpu_rvalid=0 after that edge; no gnt, MemRead=MemWrite=0 while reset=1; counter=0 after release.
- Back-to-back CPU streaming: 8 consecutive reads addr 0..7, dbg idle -> 8 consecutive gnts; rvalid high for 8 cycles starting one cycle later, with rdata 0..7 in order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_DBG  = 2'd2
  } req_id_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester (CPU, debug) and memory-side signals of the data-memory arbiter.
interface data_mem_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_err;

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  read_data,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output MemRead, MemWrite, ram_addr, write_data
  );

  // Requester/memory environment side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output read_data,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  MemRead, MemWrite, ram_addr, write_data
  );

endinterface

// File: rtl/mem_arb_port_resp.sv
// Per-requester response stage: registers rvalid/rdata/err one cycle after a grant.
module mem_arb_port_resp #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              granted,
  input  logic              we,
  input  logic              in_range,
  input  logic [DATA_W-1:0] read_data,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  // rdata only moves on a granted read; out-of-range reads return zero
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= granted && !we;
      err    <= granted && !in_range;
      if (granted && !we) begin
        rdata <= in_range ? read_data : '0;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the CPU LSU and the debug/loader port;
// CPU wins conflicts until debug has lost STARVE_LIMIT cycles in a row.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MEM_WORDS    = 32,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  req_id_e           sel;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starved;
  logic              cpu_gnt;
  logic              dbg_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;

  assign starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  // Grant selection; nothing is granted while reset is held
  always_comb begin
    sel = REQ_NONE;
    if (!reset) begin
      if (bus.cpu_req && bus.dbg_req) begin
        sel = starved ? REQ_DBG : REQ_CPU;
      end else if (bus.cpu_req) begin
        sel = REQ_CPU;
      end else if (bus.dbg_req) begin
        sel = REQ_DBG;
      end
    end
  end

  // Mux the winning request onto the memory; idle bus is driven to zero
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (sel)
      REQ_CPU: begin
        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
      end
      REQ_DBG: begin
        sel_we    = bus.dbg_we;
        sel_addr  = bus.dbg_addr;
        sel_wdata = bus.dbg_wdata;
      end
      default: ;
    endcase
  end

  assign in_range = (sel_addr < ADDR_W'(MEM_WORDS));
  assign cpu_gnt  = (sel == REQ_CPU);
  assign dbg_gnt  = (sel == REQ_DBG);

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.ram_addr   = sel_addr;
  assign bus.write_data = sel_wdata;
  assign bus.MemWrite   = (sel != REQ_NONE) && sel_we && in_range;
  assign bus.MemRead    = (sel != REQ_NONE) && !sel_we;

  // Counts consecutive cycles debug waited; saturates at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (dbg_gnt || !bus.dbg_req) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  mem_arb_port_resp #(.DATA_W(DATA_W)) u_cpu_resp (
    .clk       (clk),
    .reset     (reset),
    .granted   (cpu_gnt),
    .we        (bus.cpu_we),
    .in_range  (in_range),
    .read_data (bus.read_data),
    .rvalid    (bus.cpu_rvalid),
    .rdata     (bus.cpu_rdata),
    .err       (bus.cpu_err)
  );

  mem_arb_port_resp #(.DATA_W(DATA_W)) u_dbg_resp (
    .clk       (clk),
    .reset     (reset),
    .granted   (dbg_gnt),
    .we        (bus.dbg_we),
    .in_range  (in_range),
    .read_data (bus.read_data),
    .rvalid    (bus.dbg_rvalid),
    .rdata     (bus.dbg_rdata),
    .err       (bus.dbg_err)
  );

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: queue-driven requesters, a 32-word memory, a per-cycle
// reference model, and directed scenarios with hand-computed expectations.
module tb_data_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned WORDS = 32;
  localparam int unsigned LIMIT = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  data_mem_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_WORDS(WORDS), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: write at posedge, combinational read; out-of-range reads return junk
  logic [DW-1:0] ram [WORDS];
  always @(posedge clk)
    if (bus.MemWrite && bus.ram_addr < AW'(WORDS)) ram[bus.ram_addr[4:0]] = bus.write_data;
  assign bus.read_data = (bus.ram_addr < AW'(WORDS)) ? ram[bus.ram_addr[4:0]]
                                                     : (32'hBAD0_0000 ^ bus.ram_addr);

  // Requester agents: hold head of queue until granted
  txn_t cpu_q[$];
  txn_t dbg_q[$];
  logic cpu_taken = 1'b0;
  logic dbg_taken = 1'b0;

  function automatic txn_t mk(input logic we, input int unsigned a, input logic [DW-1:0] wd);
    txn_t t;
    t.we = we; t.addr = AW'(a); t.wdata = wd;
    return t;
  endfunction

  initial begin : cpu_agent
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (cpu_taken && cpu_q.size() > 0) void'(cpu_q.pop_front());
      if (cpu_q.size() > 0) begin
        bus.cpu_req = 1'b1; bus.cpu_we = cpu_q[0].we;
        bus.cpu_addr = cpu_q[0].addr; bus.cpu_wdata = cpu_q[0].wdata;
      end else begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      end
    end
  end

  initial begin : dbg_agent
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    forever begin
      @(posedge clk); #1;
      if (dbg_taken && dbg_q.size() > 0) void'(dbg_q.pop_front());
      if (dbg_q.size() > 0) begin
        bus.dbg_req = 1'b1; bus.dbg_we = dbg_q[0].we;
        bus.dbg_addr = dbg_q[0].addr; bus.dbg_wdata = dbg_q[0].wdata;
      end else begin
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
      end
    end
  end

  // Reference model state and observation logs
  logic [DW-1:0] model_mem [WORDS];
  int            m_wait = 0;
  logic          x_crv = 1'b0, x_cerr = 1'b0, x_drv = 1'b0, x_derr = 1'b0;
  logic [DW-1:0] x_crd = '0, x_drd = '0;
  int   cpu_g[$];
  int   dbg_g[$];
  ev_t  cpu_rd[$];
  ev_t  dbg_rd[$];
  int   dbg_errs = 0, cpu_errs = 0, mw_cnt = 0, rst_act = 0;

  always @(negedge clk) begin : compare
    logic          e_cg, e_dg, e_we, e_in, e_mr, e_mw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    ev_t           ev;

    e_cg = 1'b0; e_dg = 1'b0;
    if (!reset) begin
      if (bus.cpu_req && bus.dbg_req) begin
        if (m_wait >= int'(LIMIT)) e_dg = 1'b1; else e_cg = 1'b1;
      end else if (bus.cpu_req) e_cg = 1'b1;
      else if (bus.dbg_req) e_dg = 1'b1;
    end
    e_we   = e_cg ? bus.cpu_we   : (e_dg ? bus.dbg_we   : 1'b0);
    e_addr = e_cg ? bus.cpu_addr : (e_dg ? bus.dbg_addr : '0);
    e_wd   = e_cg ? bus.cpu_wdata: (e_dg ? bus.dbg_wdata: '0);
    e_in   = (e_addr < AW'(WORDS));
    e_mr   = (e_cg || e_dg) && !e_we;
    e_mw   = (e_cg || e_dg) && e_we && e_in;

    check("cpu_gnt",    32'(bus.cpu_gnt),    32'(e_cg));
    check("dbg_gnt",    32'(bus.dbg_gnt),    32'(e_dg));
    check("MemRead",    32'(bus.MemRead),    32'(e_mr));
    check("MemWrite",   32'(bus.MemWrite),   32'(e_mw));
    check("ram_addr",   bus.ram_addr,        e_addr);
    check("write_data", bus.write_data,      e_wd);
    check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(x_crv));
    check("cpu_rdata",  bus.cpu_rdata,       x_crd);
    check("cpu_err",    32'(bus.cpu_err),    32'(x_cerr));
    check("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(x_drv));
    check("dbg_rdata",  bus.dbg_rdata,       x_drd);
    check("dbg_err",    32'(bus.dbg_err),    32'(x_derr));

    if (bus.cpu_gnt === 1'b1) cpu_g.push_back(cyc);
    if (bus.dbg_gnt === 1'b1) dbg_g.push_back(cyc);
    if (bus.cpu_rvalid === 1'b1) begin ev.cyc = cyc; ev.d = bus.cpu_rdata; cpu_rd.push_back(ev); end
    if (bus.dbg_rvalid === 1'b1) begin ev.cyc = cyc; ev.d = bus.dbg_rdata; dbg_rd.push_back(ev); end
    if (bus.dbg_err === 1'b1) dbg_errs++;
    if (bus.cpu_err === 1'b1) cpu_errs++;
    if (bus.MemWrite === 1'b1) mw_cnt++;
    if (reset && (bus.cpu_gnt || bus.dbg_gnt || bus.MemRead || bus.MemWrite)) rst_act++;
    cpu_taken = (bus.cpu_gnt === 1'b1);
    dbg_taken = (bus.dbg_gnt === 1'b1);

    // Expected state after the coming posedge
    if (reset) begin
      x_crv = 1'b0; x_cerr = 1'b0; x_crd = '0;
      x_drv = 1'b0; x_derr = 1'b0; x_drd = '0;
      m_wait = 0;
    end else begin
      x_crv  = e_cg && !bus.cpu_we;
      x_cerr = e_cg && !e_in;
      if (x_crv) x_crd = e_in ? model_mem[e_addr[4:0]] : '0;
      x_drv  = e_dg && !bus.dbg_we;
      x_derr = e_dg && !e_in;
      if (x_drv) x_drd = e_in ? model_mem[e_addr[4:0]] : '0;
      if (bus.dbg_req && !e_dg) m_wait++; else m_wait = 0;
      if (e_mw) model_mem[e_addr[4:0]] = e_wd;
    end
  end

  task automatic clear_logs();
    cpu_g.delete(); dbg_g.delete(); cpu_rd.delete(); dbg_rd.delete();
    dbg_errs = 0; cpu_errs = 0; mw_cnt = 0; rst_act = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((cpu_q.size() > 0 || dbg_q.size() > 0) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) begin
      n_vec++; n_bad++;
      $display("FAIL %s_timeout: queues still hold cpu=%0d dbg=%0d", name, cpu_q.size(), dbg_q.size());
    end
    repeat (3) begin @(negedge clk); #1; end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int rst_cyc, rel_cyc, n, in_win;
    for (int i = 0; i < int'(WORDS); i++) begin
      ram[i] = DW'(i); model_mem[i] = DW'(i);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;

    // Streaming: 8 back-to-back CPU reads of addr 0..7
    clear_logs();
    for (int i = 0; i < 8; i++) cpu_q.push_back(mk(1'b0, i, '0));
    drain("stream");
    check("stream_gnt_cnt", cpu_g.size(), 8);
    for (int i = 0; i < cpu_g.size(); i++) check("stream_gnt_cyc", cpu_g[i], cpu_g[0] + i);
    check("stream_rvalid_cnt", cpu_rd.size(), 8);
    for (int i = 0; i < cpu_rd.size(); i++) begin
      check("stream_rdata", cpu_rd[i].d, i);
      check("stream_rd_cyc", cpu_rd[i].cyc, cpu_g[0] + 1 + i);
    end
    check("stream_dbg_quiet", dbg_g.size() + dbg_rd.size(), 0);

    // Conflict: CPU reads 3 and debug reads 7 in the same cycle
    clear_logs();
    cpu_q.push_back(mk(1'b0, 3, '0));
    dbg_q.push_back(mk(1'b0, 7, '0));
    drain("conflict");
    check("conf_cpu_gnts", cpu_g.size(), 1);
    check("conf_dbg_gnts", dbg_g.size(), 1);
    check("conf_order", dbg_g[0] - cpu_g[0], 1);
    check("conf_cpu_rdata", cpu_rd[0].d, 3);
    check("conf_dbg_rdata", dbg_rd[0].d, 7);
    check("conf_rd_spacing", dbg_rd[0].cyc - cpu_rd[0].cyc, 1);

    // Starvation: CPU streams 12 reads, debug wants addr 9 then 10
    clear_logs();
    for (int i = 0; i < 12; i++) cpu_q.push_back(mk(1'b0, i, '0));
    dbg_q.push_back(mk(1'b0, 9, '0));
    dbg_q.push_back(mk(1'b0, 10, '0));
    drain("starve");
    check("starve_dbg_gnts", dbg_g.size(), 2);
    check("starve_first_wait", dbg_g[0] - cpu_g[0], 4);
    check("starve_cpu_yield", cpu_g[4], dbg_g[0] + 1);
    check("starve_second_wait", dbg_g[1] - dbg_g[0], 5);
    check("starve_cpu_resume", cpu_g[8], dbg_g[1] + 1);
    check("starve_dbg_rd0", dbg_rd[0].d, 9);
    check("starve_dbg_rd1", dbg_rd[1].d, 10);
    check("starve_cpu_cnt", cpu_g.size(), 12);

    // CPU write 0xDEADBEEF to addr 5, then read it back
    clear_logs();
    cpu_q.push_back(mk(1'b1, 5, 32'hDEAD_BEEF));
    cpu_q.push_back(mk(1'b0, 5, '0));
    drain("wr_rd");
    check("wr_rd_gnts", cpu_g.size(), 2);
    check("wr_rd_b2b", cpu_g[1] - cpu_g[0], 1);
    check("wr_rd_rvalid_cnt", cpu_rd.size(), 1);
    check("wr_rd_rdata", cpu_rd[0].d, 32'hDEAD_BEEF);
    check("wr_rd_latency", cpu_rd[0].cyc, cpu_g[1] + 1);
    check("wr_rd_memwrite", mw_cnt, 1);
    check("wr_rd_dbg_quiet", dbg_g.size() + dbg_rd.size() + dbg_errs, 0);

    // Out of range: debug write then read of addr 40
    clear_logs();
    dbg_q.push_back(mk(1'b1, 40, 32'h0000_1234));
    dbg_q.push_back(mk(1'b0, 40, '0));
    drain("oor");
    check("oor_gnts", dbg_g.size(), 2);
    check("oor_memwrite", mw_cnt, 0);
    check("oor_err_pulses", dbg_errs, 2);
    check("oor_rvalid_cnt", dbg_rd.size(), 1);
    check("oor_rdata", dbg_rd[0].d, 0);
    check("oor_cpu_err", cpu_errs, 0);

    // Reset right after a granted CPU read; requests pending across reset
    clear_logs();
    cpu_q.push_back(mk(1'b0, 2, '0));
    n = 0;
    while (cpu_g.size() == 0 && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) begin
      n_vec++; n_bad++;
      $display("FAIL rst_gnt_timeout: cpu read never granted");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    rst_cyc = cyc;
    cpu_q.push_back(mk(1'b0, 4, '0));
    dbg_q.push_back(mk(1'b0, 6, '0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rel_cyc = cyc;
    drain("reset");
    check("rst_pending_rvalid_cyc", cpu_rd[0].cyc, rst_cyc);
    check("rst_pending_rdata", cpu_rd[0].d, 2);
    check("rst_no_activity", rst_act, 0);
    in_win = 0;
    foreach (cpu_rd[i]) if (cpu_rd[i].cyc > rst_cyc && cpu_rd[i].cyc < rel_cyc) in_win++;
    check("rst_rvalid_cleared", in_win, 0);
    check("rst_cpu_first", cpu_g[1], rel_cyc);
    check("rst_dbg_next", dbg_g[0], rel_cyc + 1);
    check("rst_cpu_rdata", cpu_rd[1].d, 4);
    check("rst_dbg_rdata", dbg_rd[0].d, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
